// File: rtl/water_pump_scheduler.sv
// water_pump_scheduler: shares one supply pump among N_TANKS reservoirs.
// Tracks the level band and fill direction of each tank, grants the pump
// round-robin to tanks below full with a grant cap and a one-cycle valve
// gap, and decodes the flow valves for the granted tank.
// Optional feature: define WATER_SENSOR_CHECK_EN to flag and mask tanks that
// report impossible sensor codes.
module water_pump_scheduler #(
    parameter int N_TANKS   = 4,
    parameter int MAX_GRANT = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [3*N_TANKS-1:0]       level,
    output logic [N_TANKS-1:0]         grant,
    output logic [$clog2(N_TANKS)-1:0] gnt_id,
    output logic                       fr3,
    output logic                       fr2,
    output logic                       fr1,
    output logic                       dfr,
    output logic                       busy,
    output logic [N_TANKS-1:0]         sensor_err
);

    localparam int IW = $clog2(N_TANKS);
    localparam int CW = $clog2(MAX_GRANT);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_GRANT - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GRANT  = 2'd1;
    localparam logic [1:0] ST_SWITCH = 2'd2;

    logic [1:0]         state;
    logic [IW-1:0]      ptr;
    logic [CW-1:0]      cnt;
    logic [1:0]         band_q   [N_TANKS];
    logic [1:0]         band_new [N_TANKS];
    logic [N_TANKS-1:0] dir_q;
    logic [N_TANKS-1:0] code_bad;
    logic [N_TANKS-1:0] masked;
    logic [N_TANKS-1:0] req;
    logic               win_found;
    logic [IW-1:0]      win_idx;
    logic               cur_req;
    logic               other_req;
    logic [1:0]         gnt_band;
    logic               gnt_dir;

    // Decode each tank's sensor column into a level band.
    always_comb begin
        for (int unsigned i = 0; i < N_TANKS; i++) begin
            band_new[i] = band_q[i];
            code_bad[i] = 1'b0;
`ifdef WATER_SENSOR_CHECK_EN
            case (level[3*i +: 3])
                3'b000:  band_new[i] = 2'd0;
                3'b001:  band_new[i] = 2'd1;
                3'b011:  band_new[i] = 2'd2;
                3'b111:  band_new[i] = 2'd3;
                default: code_bad[i] = 1'b1;
            endcase
`else
            casez (level[3*i +: 3])
                3'b1??:  band_new[i] = 2'd3;
                3'b01?:  band_new[i] = 2'd2;
                3'b001:  band_new[i] = 2'd1;
                default: band_new[i] = 2'd0;
            endcase
`endif
        end
    end

    // Track band and fill direction for every tank, every cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < N_TANKS; i++) begin
                band_q[i] <= 2'd0;
                dir_q[i]  <= 1'b1;
            end
        end else begin
            for (int unsigned i = 0; i < N_TANKS; i++) begin
                if (!code_bad[i]) begin
                    if (band_new[i] < band_q[i])
                        dir_q[i] <= 1'b1;
                    else if (band_new[i] > band_q[i])
                        dir_q[i] <= 1'b0;
                    band_q[i] <= band_new[i];
                end
            end
        end
    end

`ifdef WATER_SENSOR_CHECK_EN
    // Latch sensor faults until reset; a faulty tank never requests again.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            sensor_err <= '0;
        else
            sensor_err <= sensor_err | code_bad;
    end
    assign masked = sensor_err;
`else
    assign sensor_err = '0;
    assign masked     = '0;
`endif

    // Request generation and round-robin winner search starting at ptr.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned i = 0; i < N_TANKS; i++)
            req[i] = (band_q[i] != 2'd3) && !masked[i];
        for (int unsigned k = 0; k < N_TANKS; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= N_TANKS)
                idx = idx - N_TANKS;
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_idx   = IW'(idx);
            end
        end
        cur_req   = |(req & grant);
        other_req = |(req & ~grant);
    end

    // Grant FSM. ptr is advanced on entry to SWITCH so the winner search out
    // of SWITCH already starts just past the released tank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            grant  <= '0;
            gnt_id <= '0;
            busy   <= 1'b0;
            ptr    <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_SWITCH: begin
                    if (win_found) begin
                        state  <= ST_GRANT;
                        grant  <= N_TANKS'(1) << win_idx;
                        gnt_id <= win_idx;
                        busy   <= 1'b1;
                        cnt    <= '0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    if (!cur_req || (cnt == CNT_LAST && other_req)) begin
                        state  <= ST_SWITCH;
                        grant  <= '0;
                        gnt_id <= '0;
                        busy   <= 1'b0;
                        ptr    <= (gnt_id == IW'(N_TANKS - 1)) ? '0 : gnt_id + 1'b1;
                    end else if (cnt != CNT_LAST) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    grant  <= '0;
                    gnt_id <= '0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

    assign gnt_band = band_q[gnt_id];
    assign gnt_dir  = dir_q[gnt_id];

    // Flow valves for the granted tank, closed whenever no grant is held.
    always_comb begin
        fr3 = 1'b0;
        fr2 = 1'b0;
        fr1 = 1'b0;
        dfr = 1'b0;
        if (busy) begin
            case (gnt_band)
                2'd0: begin fr3 = 1'b1; fr2 = 1'b1; fr1 = 1'b1; end
                2'd1: begin fr2 = 1'b1; fr1 = 1'b1; end
                2'd2: fr1 = 1'b1;
                default: ;
            endcase
            dfr = gnt_dir && (gnt_band != 2'd3);
        end
    end

endmodule

// File: tb/tb_water_pump_scheduler.sv
// Self-checking bench for water_pump_scheduler with N_TANKS=4, MAX_GRANT=4.
// Directed scenarios followed by random level traffic, all checked against a
// cycle-level behavioural model of the pump schedule.
module tb_water_pump_scheduler;

    localparam int NT = 4;
    localparam int MG = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [3*NT-1:0] level = '0;
    logic [NT-1:0]   grant;
    logic [1:0]      gnt_id;
    logic            fr3, fr2, fr1, dfr, busy;
    logic [NT-1:0]   sensor_err;

    int total = 0;
    int bad   = 0;

    // model state
    int m_band [NT];
    int m_dir  [NT];
    int m_err  [NT];
    int m_phase;   // 0 idle, 1 pumping, 2 valve gap
    int m_cur;
    int m_ptr;
    int m_held;

    water_pump_scheduler #(.N_TANKS(NT), .MAX_GRANT(MG)) dut (
        .clk(clk), .reset(reset), .level(level), .grant(grant), .gnt_id(gnt_id),
        .fr3(fr3), .fr2(fr2), .fr1(fr1), .dfr(dfr), .busy(busy),
        .sensor_err(sensor_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3*NT-1:0] mk(input int t3, input int t2, input int t1, input int t0);
        logic [3*NT-1:0] v;
        v = {3'(t3), 3'(t2), 3'(t1), 3'(t0)};
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NT; i++) begin
            m_band[i] = 0; m_dir[i] = 1; m_err[i] = 0;
        end
        m_phase = 0; m_cur = 0; m_ptr = 0; m_held = 0;
    endtask

    function automatic bit wants(input int i);
        return (m_band[i] < 3) && (m_err[i] == 0);
    endfunction

    task automatic pick(output bit found, output int who);
        found = 0; who = 0;
        for (int k = 0; k < NT; k++) begin
            int t;
            t = (m_ptr + k) % NT;
            if (!found && wants(t)) begin found = 1; who = t; end
        end
    endtask

    task automatic model_edge(input logic [3*NT-1:0] lv);
        bit found, others;
        int who;
        // schedule decision uses the bands known before this edge
        if (m_phase == 1) begin
            others = 0;
            for (int j = 0; j < NT; j++)
                if (j != m_cur && wants(j)) others = 1;
            if (!wants(m_cur) || (m_held >= MG - 1 && others)) begin
                m_phase = 2;
                m_ptr = (m_cur + 1) % NT;
            end else begin
                m_held++;
            end
        end else begin
            pick(found, who);
            if (found) begin m_phase = 1; m_cur = who; m_held = 0; end
            else m_phase = 0;
        end
        // sensor interpretation
        for (int i = 0; i < NT; i++) begin
            logic [2:0] c;
            int nb;
            bit ok;
            c = lv[3*i +: 3];
            ok = 1;
`ifdef WATER_SENSOR_CHECK_EN
            if (c == 3'b000) nb = 0;
            else if (c == 3'b001) nb = 1;
            else if (c == 3'b011) nb = 2;
            else if (c == 3'b111) nb = 3;
            else begin nb = 0; ok = 0; end
`else
            nb = c[2] ? 3 : (c[1] ? 2 : (c[0] ? 1 : 0));
`endif
            if (!ok) m_err[i] = 1;
            else begin
                if (nb < m_band[i]) m_dir[i] = 1;
                else if (nb > m_band[i]) m_dir[i] = 0;
                m_band[i] = nb;
            end
        end
    endtask

    task automatic compare_model(input string where);
        logic [NT-1:0] eg, ee;
        int b;
        bit on;
        on = (m_phase == 1);
        eg = on ? NT'(1) << m_cur : '0;
        ee = '0;
        for (int i = 0; i < NT; i++) ee[i] = m_err[i][0];
        b = on ? m_band[m_cur] : 3;
        chk({where, ".grant"}, 32'(grant), 32'(eg));
        chk({where, ".gnt_id"}, 32'(gnt_id), on ? 32'(m_cur) : 0);
        chk({where, ".busy"}, 32'(busy), 32'(on));
        chk({where, ".flow"}, 32'({fr3, fr2, fr1}), 32'({b < 1, b < 2, b < 3}));
        chk({where, ".dfr"}, 32'(dfr), 32'(on && m_dir[m_cur] == 1 && b < 3));
        chk({where, ".sensor_err"}, 32'(sensor_err), 32'(ee));
    endtask

    task automatic step(input string where);
        @(posedge clk);
        model_edge(level);
        #1;
        compare_model(where);
    endtask

    task automatic do_reset(input string where);
        reset = 1'b1;
        #1;
        chk({where, ".rst_grant"}, 32'(grant), 0);
        chk({where, ".rst_outs"}, 32'({gnt_id, fr3, fr2, fr1, dfr, busy}), 0);
        chk({where, ".rst_err"}, 32'(sensor_err), 0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        model_reset();
        // power-on reset with every tank empty
        level = '0;
        #2;
        do_reset("por");
        step("first");
        chk("first.grant_const", 32'(grant), 32'h1);
        chk("first.flow_const", 32'({fr3, fr2, fr1, dfr, busy}), 32'h1f);

        // tank 0 fills while the others are full
        level = mk(7, 7, 7, 1); step("fill1");
        level = mk(7, 7, 7, 3); step("fill2");
        level = mk(7, 7, 7, 7); step("fill3");
        step("fill4");
        chk("fill4.gap", 32'(grant), 0);
        step("fill5");

        // tank 0 falling from band 2 to band 1
        level = mk(7, 7, 7, 3); for (int i = 0; i < 3; i++) step("fall_a");
        level = mk(7, 7, 7, 1); step("fall_b");
        chk("fall_b.flow_const", 32'({fr3, fr2, fr1, dfr}), 32'b0111);

        // tanks 1 and 3 empty: capped alternation with one-cycle gaps
        do_reset("alt");
        level = mk(0, 7, 0, 7);
        for (int i = 0; i < 14; i++) step("alt");

        // reset asserted in the middle of a grant
        do_reset("mid0");
        level = mk(7, 7, 0, 7);
        for (int i = 0; i < 4; i++) step("mid");
        #2;
        do_reset("mid1");
        level = mk(0, 7, 0, 0);
        for (int i = 0; i < 4; i++) step("restart");

        // tank 2 reports an impossible code while granted
        do_reset("bad0");
        level = mk(7, 0, 7, 7);
        for (int i = 0; i < 3; i++) step("bad_a");
        level = mk(7, 5, 7, 7); for (int i = 0; i < 3; i++) step("bad_b");
        level = mk(7, 0, 0, 7); for (int i = 0; i < 10; i++) step("bad_c");

        // random traffic, mostly legal codes with occasional oddities
        do_reset("rnd0");
        for (int n = 0; n < 800; n++) begin
            logic [3*NT-1:0] lv;
            lv = level;
            for (int i = 0; i < NT; i++) begin
                if ($urandom_range(0, 7) == 0) begin
                    int pick_c;
                    pick_c = $urandom_range(0, 3);
                    if ($urandom_range(0, 15) == 0)
                        lv[3*i +: 3] = 3'($urandom_range(0, 7));
                    else
                        lv[3*i +: 3] = (pick_c == 0) ? 3'b000 : (pick_c == 1) ? 3'b001 :
                                       (pick_c == 2) ? 3'b011 : 3'b111;
                end
            end
            level = lv;
            if ($urandom_range(0, 199) == 0) begin
                #2;
                do_reset("rnd_rst");
            end else begin
                step("rnd");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
